// File: rtl/cubic_pkg.sv
// cubic_pkg: shared state type and default widths/fractions for the Horner cubic evaluator
package cubic_pkg;
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
  localparam int CH_IN_W = 10;
  localparam int CH_IN_FRAC = 7;
  localparam int CH_COEF_W = 10;
  localparam int CH_COEF_FRAC = 7;
  localparam int CH_OUT_W = 10;
  localparam int CH_OUT_FRAC = 6;
  localparam int CH_ACC_W = 24;
endpackage

// File: rtl/cubic_sat.sv
// cubic_sat: arithmetic right shift by SH then clamp signed IW-bit d into signed OW-bit q; clip flags a clamp
module cubic_sat #(
  parameter int IW = 35,
  parameter int OW = 24,
  parameter int SH = 0
) (
  input  logic signed [IW-1:0] d,
  output logic signed [OW-1:0] q,
  output logic                 clip
);
  logic signed [IW-1:0] s;
  logic [IW-OW:0] top;
  always_comb begin
    s = d >>> SH;
    top = s[IW-1:OW-1];
    clip = !((&top) || !(|top));
    q = clip ? (s[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}}) : s[OW-1:0];
  end
endmodule

// File: rtl/cubic_horner.sv
// cubic_horner: y = a*x^3 + b*x^2 + c*x + d by Horner's rule, one shared multiplier, three STEP cycles.
// Ports: clk, reset_n (async active-low); in_valid/in_ready accept x (in) and coef_a..coef_d;
// out_valid/out_ready hand over out (signed result) and sat (sticky clamp flag of this evaluation).
module cubic_horner
  import cubic_pkg::*;
#(
  parameter int IN_W = CH_IN_W,
  parameter int IN_FRAC = CH_IN_FRAC,
  parameter int COEF_W = CH_COEF_W,
  parameter int COEF_FRAC = CH_COEF_FRAC,
  parameter int OUT_W = CH_OUT_W,
  parameter int OUT_FRAC = CH_OUT_FRAC,
  parameter int ACC_W = CH_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IN_W-1:0]   in,
  input  logic signed [COEF_W-1:0] coef_a,
  input  logic signed [COEF_W-1:0] coef_b,
  input  logic signed [COEF_W-1:0] coef_c,
  input  logic signed [COEF_W-1:0] coef_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out,
  output logic                     sat
);
  localparam int PW = ACC_W + IN_W;
  state_t state, nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [IN_W-1:0] xr;
  logic signed [COEF_W-1:0] br, cr, dr, coef;
  logic [1:0] cnt;
  logic signed [PW-1:0] prod;
  logic signed [PW:0] sum;
  logic signed [OUT_W-1:0] out_nxt;
  logic clip_a, clip_o;
  always_comb begin
    coef = cnt == 2'd0 ? br : cnt == 2'd1 ? cr : dr;
    prod = PW'(acc) * PW'(xr);
    sum = (PW+1)'(prod >>> IN_FRAC) + (PW+1)'(coef);
    nxt = state == IDLE ? (in_valid ? STEP : IDLE)
        : state == STEP ? (cnt == 2'd2 ? DONE : STEP)
        : (out_ready ? IDLE : DONE);
  end
  cubic_sat #(.IW(PW+1), .OW(ACC_W), .SH(0)) u_sat_acc (.d(sum), .q(acc_nxt), .clip(clip_a));
  // Final clamp reads the freshly computed accumulator so out lands on the same edge as DONE.
  cubic_sat #(.IW(ACC_W), .OW(OUT_W), .SH(COEF_FRAC-OUT_FRAC)) u_sat_out (.d(acc_nxt), .q(out_nxt), .clip(clip_o));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc <= '0;
      xr <= '0;
      br <= '0;
      cr <= '0;
      dr <= '0;
      cnt <= '0;
      out <= '0;
      sat <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        xr <= in;
        br <= coef_b;
        cr <= coef_c;
        dr <= coef_d;
        acc <= ACC_W'(coef_a);
        cnt <= '0;
        sat <= 1'b0;
      end else if (state == STEP) begin
        acc <= acc_nxt;
        cnt <= cnt + 2'd1;
        sat <= sat | clip_a | (cnt == 2'd2 && clip_o);
        if (cnt == 2'd2) out <= out_nxt;
      end
    end
  end
endmodule

// File: tb/tb_cubic_horner.sv
// tb_cubic_horner: directed checks of the Horner cubic evaluator
module tb_cubic_horner;
  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, out_valid, out_ready, sat;
  logic signed [9:0] in, coef_a, coef_b, coef_c, coef_d, out;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  cubic_horner dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .sat(sat)
  );
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic start(input int xv, input int av, input int bv, input int cv, input int dv);
    chk("ready_before_accept", in_ready, 1);
    in = 10'(xv);
    coef_a = 10'(av);
    coef_b = 10'(bv);
    coef_c = 10'(cv);
    coef_d = 10'(dv);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    coef_a = 10'(7);
    in = 10'(-3);
  endtask
  task automatic go(input int xv, input int av, input int bv, input int cv, input int dv);
    int cyc;
    start(xv, av, bv, cv, dv);
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 3);
  endtask
  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_cleared", out_valid, 0);
    chk("ready_after_take", in_ready, 1);
  endtask
  initial begin
    longint a2, a3, o;
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in = '0;
    coef_a = '0;
    coef_b = '0;
    coef_c = '0;
    coef_d = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_sat", sat, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    go(511, 128, 0, 0, 0);
    chk("x511_out", out, 511);
    chk("x511_sat", sat, 1);
    take();
    go(-512, 128, 0, 0, 0);
    chk("xm512_out", out, -512);
    chk("xm512_sat", sat, 1);
    take();
    go(128, 128, 0, 0, 0);
    chk("x1_out", out, 64);
    chk("x1_sat", sat, 0);
    take();
    go(64, 128, 0, 0, 0);
    chk("xhalf_out", out, 8);
    take();
    go(-64, 128, 0, 0, 0);
    chk("xmhalf_out", out, -8);
    chk("xmhalf_sat", sat, 0);
    take();
    go(128, 128, 128, 128, 128);
    chk("all1_out", out, 256);
    chk("all1_sat", sat, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in = 10'($urandom);
      coef_a = 10'($urandom);
      @(negedge clk);
      chk("hold_out", out, 256);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    take();
    start(511, 128, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out", out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    go(64, 128, 0, 0, 0);
    chk("postrst_out", out, 8);
    chk("postrst_sat", sat, 0);
    take();
    for (int x = -512; x <= 511; x += 8) begin
      a2 = (longint'(x) * x) >>> 7;
      a3 = (a2 * x) >>> 7;
      o = a3 >>> 1;
      o = o > 511 ? 511 : o < -512 ? -512 : o;
      go(x, 128, 0, 0, 0);
      chk($sformatf("sweep_x%0d", x), out, 32'(o));
      take();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
